// File: rtl/opd_32_decoder.sv
// ---------------------------------------------------------------------------
// opd_32_decoder
//
// Registered instruction decoder for the 32-bit CaballoLoco datapath. It splits
// a fetched instruction into register selects, control flags, ALU and compare
// opcodes, and a sign-extended offset. It produces one decoded bundle per
// cycle, with a latency of one clock.
//
// Optional feature macro: OPD_32_ILLEGAL_EN
//   When defined, reserved opcodes 13..15 drive o_illegal=1 for the cycle in
//   which they are decoded.
//   When undefined, o_illegal is tied to 0 and reserved opcodes decode
//   silently as bubbles.
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst          asynchronous active-high reset (clears to bubble, sel=0)
//   i_instruction  32-bit instruction word
//   i_nop          decode a bubble (selects still taken from the fields)
//   i_stall        hold every output; instruction and nop are ignored
//   o_select_a/b/c register fields A (destination), B and C (sources)
//   o_is_write     register write-back
//   o_is_load      memory load
//   o_is_store     memory store
//   o_is_cmp       control transfer (branch or jump)
//   o_cmp_op       EQ/LT/LE/ALWAYS
//   o_alu_op       ADD/SUB/AND/OR/MUL/DIV/XOR
//   o_offset       sign-extended immediate
//   o_illegal      reserved opcode seen (only with OPD_32_ILLEGAL_EN)
// ---------------------------------------------------------------------------
package opd_32_pkg;

  typedef enum logic [1:0] {
    CMP_EQ     = 2'd0,
    CMP_LT     = 2'd1,
    CMP_LE     = 2'd2,
    CMP_ALWAYS = 2'd3
  } cmp_op_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_MUL = 3'd4,
    ALU_DIV = 3'd5,
    ALU_XOR = 3'd6
  } alu_op_e;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_MUL = 4'd4,
    OP_DIV = 4'd5,
    OP_XOR = 4'd6,
    OP_LW  = 4'd7,
    OP_SW  = 4'd8,
    OP_BEQ = 4'd9,
    OP_BLT = 4'd10,
    OP_BLE = 4'd11,
    OP_JMP = 4'd12
  } opcode_e;

endpackage

module opd_32_decoder
  import opd_32_pkg::*;
#(
  parameter int NUM_REG    = 32,
  localparam int REG_SELECT = $clog2(NUM_REG)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [31:0]           i_instruction,
  input  logic                  i_nop,
  input  logic                  i_stall,
  output logic [REG_SELECT-1:0] o_select_a,
  output logic [REG_SELECT-1:0] o_select_b,
  output logic [REG_SELECT-1:0] o_select_c,
  output logic                  o_is_write,
  output logic                  o_is_load,
  output logic                  o_is_store,
  output logic                  o_is_cmp,
  output cmp_op_e               o_cmp_op,
  output alu_op_e               o_alu_op,
  output logic [31:0]           o_offset,
  output logic                  o_illegal
);

  localparam int REG_WIDTH = 32;

  // ---------------------------------------------------------------------
  // Field extraction
  // ---------------------------------------------------------------------
  logic [3:0]           w_opcode;
  logic [4:0]           w_field_a;
  logic [4:0]           w_field_b;
  logic [4:0]           w_field_c;
  logic [12:0]          w_imm13;
  logic [27:0]          w_imm28;
  logic [REG_WIDTH-1:0] w_sext13;
  logic [REG_WIDTH-1:0] w_sext28;

  assign w_opcode  = i_instruction[31:28];
  assign w_field_a = i_instruction[27:23];
  assign w_field_b = i_instruction[22:18];
  assign w_field_c = i_instruction[17:13];
  assign w_imm13   = i_instruction[12:0];
  assign w_imm28   = i_instruction[27:0];

  // Loads, stores and branches use the 13-bit immediate. A jump reuses the
  // register fields as part of a 28-bit displacement.
  assign w_sext13 = {{(REG_WIDTH-13){w_imm13[12]}}, w_imm13};
  assign w_sext28 = {{(REG_WIDTH-28){w_imm28[27]}}, w_imm28};

  // ---------------------------------------------------------------------
  // Combinational decode of the next bundle
  // ---------------------------------------------------------------------
  logic                 w_is_write_next;
  logic                 w_is_load_next;
  logic                 w_is_store_next;
  logic                 w_is_cmp_next;
  cmp_op_e              w_cmp_op_next;
  alu_op_e              w_alu_op_next;
  logic [REG_WIDTH-1:0] w_offset_next;

  always_comb begin
    // The bubble values are the defaults. Nops and reserved opcodes keep
    // them unchanged.
    w_is_write_next = 1'b0;
    w_is_load_next  = 1'b0;
    w_is_store_next = 1'b0;
    w_is_cmp_next   = 1'b0;
    w_cmp_op_next   = CMP_EQ;
    w_alu_op_next   = ALU_ADD;
    w_offset_next   = '0;

    if (!i_nop) begin
      case (w_opcode)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_DIV, OP_XOR: begin
          // The ALU opcodes share their encoding with the low opcode bits.
          w_is_write_next = 1'b1;
          w_alu_op_next   = alu_op_e'(w_opcode[2:0]);
        end
        OP_LW: begin
          w_is_write_next = 1'b1;
          w_is_load_next  = 1'b1;
          w_offset_next   = w_sext13;
        end
        OP_SW: begin
          w_is_store_next = 1'b1;
          w_offset_next   = w_sext13;
        end
        OP_BEQ: begin
          w_is_cmp_next = 1'b1;
          w_cmp_op_next = CMP_EQ;
          w_offset_next = w_sext13;
        end
        OP_BLT: begin
          w_is_cmp_next = 1'b1;
          w_cmp_op_next = CMP_LT;
          w_offset_next = w_sext13;
        end
        OP_BLE: begin
          w_is_cmp_next = 1'b1;
          w_cmp_op_next = CMP_LE;
          w_offset_next = w_sext13;
        end
        OP_JMP: begin
          w_is_cmp_next = 1'b1;
          w_cmp_op_next = CMP_ALWAYS;
          w_offset_next = w_sext28;
        end
        default: ; // opcodes 13..15 are reserved and decode as a bubble
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------
  logic [REG_SELECT-1:0] r_select_a;
  logic [REG_SELECT-1:0] r_select_b;
  logic [REG_SELECT-1:0] r_select_c;
  logic                  r_is_write;
  logic                  r_is_load;
  logic                  r_is_store;
  logic                  r_is_cmp;
  cmp_op_e               r_cmp_op;
  alu_op_e               r_alu_op;
  logic [REG_WIDTH-1:0]  r_offset;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_select_a <= '0;
      r_select_b <= '0;
      r_select_c <= '0;
      r_is_write <= 1'b0;
      r_is_load  <= 1'b0;
      r_is_store <= 1'b0;
      r_is_cmp   <= 1'b0;
      r_cmp_op   <= CMP_EQ;
      r_alu_op   <= ALU_ADD;
      r_offset   <= '0;
    end else if (!i_stall) begin
      // The selects pass through verbatim, including for nops and reserved
      // opcodes.
      r_select_a <= REG_SELECT'(w_field_a);
      r_select_b <= REG_SELECT'(w_field_b);
      r_select_c <= REG_SELECT'(w_field_c);
      r_is_write <= w_is_write_next;
      r_is_load  <= w_is_load_next;
      r_is_store <= w_is_store_next;
      r_is_cmp   <= w_is_cmp_next;
      r_cmp_op   <= w_cmp_op_next;
      r_alu_op   <= w_alu_op_next;
      r_offset   <= w_offset_next;
    end
  end

  assign o_select_a = r_select_a;
  assign o_select_b = r_select_b;
  assign o_select_c = r_select_c;
  assign o_is_write = r_is_write;
  assign o_is_load  = r_is_load;
  assign o_is_store = r_is_store;
  assign o_is_cmp   = r_is_cmp;
  assign o_cmp_op   = r_cmp_op;
  assign o_alu_op   = r_alu_op;
  assign o_offset   = r_offset;

`ifdef OPD_32_ILLEGAL_EN
  // A reserved opcode flags illegal only when it is actually decoded. A nop
  // masks it, and a stall holds the previous flag.
  logic w_reserved;
  logic r_illegal;

  assign w_reserved = (w_opcode > OP_JMP);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_illegal <= 1'b0;
    end else if (!i_stall) begin
      r_illegal <= w_reserved && !i_nop;
    end
  end

  assign o_illegal = r_illegal;
`else
  assign o_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_opd_32_decoder.sv
module tb_opd_32_decoder;
  import opd_32_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        nop;
  logic        stall;

  logic [4:0]  sel_a, sel_b, sel_c;
  logic        is_write, is_load, is_store, is_cmp;
  cmp_op_e     cmp_op;
  alu_op_e     alu_op;
  logic [31:0] offset;
  logic        illegal;

  int checks   = 0;
  int failures = 0;

`ifdef OPD_32_ILLEGAL_EN
  localparam bit ILLEGAL_EN = 1'b1;
`else
  localparam bit ILLEGAL_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  opd_32_decoder #(.NUM_REG(32)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_instruction (instr),
    .i_nop         (nop),
    .i_stall       (stall),
    .o_select_a    (sel_a),
    .o_select_b    (sel_b),
    .o_select_c    (sel_c),
    .o_is_write    (is_write),
    .o_is_load     (is_load),
    .o_is_store    (is_store),
    .o_is_cmp      (is_cmp),
    .o_cmp_op      (cmp_op),
    .o_alu_op      (alu_op),
    .o_offset      (offset),
    .o_illegal     (illegal)
  );

  typedef struct {
    int a, b, c;
    bit w, l, s, cm;
    int cop, aop;
    int off;
    bit ill;
  } exp_t;

  exp_t exp_q;

  function automatic exp_t bubble_state();
    exp_t e;
    e = '{a:0, b:0, c:0, w:0, l:0, s:0, cm:0, cop:0, aop:0, off:0, ill:0};
    return e;
  endfunction

  // Reference model: decoded from the instruction's meaning with integer
  // arithmetic.
  function automatic exp_t model(input logic [31:0] ins, input logic n);
    exp_t e;
    int   op;
    int   imm;
    e     = bubble_state();
    op    = int'(ins[31:28]);
    e.a   = int'(ins[27:23]);
    e.b   = int'(ins[22:18]);
    e.c   = int'(ins[17:13]);
    imm   = int'(ins[12:0]);
    if (imm >= 4096) imm = imm - 8192;
    if (n) return e;
    if (op <= 6) begin
      e.w = 1; e.aop = op;
    end else if (op == 7) begin
      e.w = 1; e.l = 1; e.off = imm;
    end else if (op == 8) begin
      e.s = 1; e.off = imm;
    end else if (op <= 11) begin
      e.cm = 1; e.cop = op - 9; e.off = imm;
    end else if (op == 12) begin
      e.cm = 1; e.cop = 3;
      e.off = int'(ins[27:0]);
      if (e.off >= (1 << 27)) e.off = e.off - (1 << 28);
    end else begin
      e.ill = ILLEGAL_EN;
    end
    return e;
  endfunction

  function automatic logic [31:0] mk(input int op, input int a, input int b,
                                    input int c, input int imm);
    logic [31:0] r;
    r = {op[3:0], a[4:0], b[4:0], c[4:0], imm[12:0]};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, want);
      end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".sel_a"},    32'(sel_a),    32'(exp_q.a));
    chk({tag, ".sel_b"},    32'(sel_b),    32'(exp_q.b));
    chk({tag, ".sel_c"},    32'(sel_c),    32'(exp_q.c));
    chk({tag, ".is_write"}, 32'(is_write), 32'(exp_q.w));
    chk({tag, ".is_load"},  32'(is_load),  32'(exp_q.l));
    chk({tag, ".is_store"}, 32'(is_store), 32'(exp_q.s));
    chk({tag, ".is_cmp"},   32'(is_cmp),   32'(exp_q.cm));
    chk({tag, ".cmp_op"},   32'(cmp_op),   32'(exp_q.cop));
    chk({tag, ".alu_op"},   32'(alu_op),   32'(exp_q.aop));
    chk({tag, ".offset"},   offset,        32'(exp_q.off));
    chk({tag, ".illegal"},  32'(illegal),  32'(exp_q.ill));
  endtask

  // One transaction: apply the inputs, clock once, update the model and
  // compare. Inputs change 1 ns after an edge, and outputs are sampled
  // 1 ns after the next edge.
  task automatic step(input string tag, input logic [31:0] ins,
                      input logic n, input logic st);
    instr = ins; nop = n; stall = st;
    @(posedge clk);
    #1;
    if (!st) exp_q = model(ins, n);
    chk_all(tag);
    $display("%s instr=%h nop=%0d stall=%0d -> sel=%0d/%0d/%0d w=%0d l=%0d s=%0d c=%0d cop=%0d aop=%0d off=%h ill=%0d",
             tag, ins, n, st, sel_a, sel_b, sel_c, is_write, is_load, is_store,
             is_cmp, cmp_op, alu_op, offset, illegal);
  endtask

  initial begin
    rst = 1'b1; instr = 32'h0; nop = 1'b0; stall = 1'b0;
    exp_q = bubble_state();
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    $display("reset: outputs at bubble");
    rst = 1'b0;

    // ALU group
    step("add", mk(0, 5, 5, 2, 0), 0, 0);
    for (int op = 1; op <= 6; op++) step("alu", mk(op, 6, 5, 3, 0), 0, 0);

    // Memory
    step("lw", mk(7, 6, 5, 3, 13'h1FFF), 0, 0);
    step("sw", mk(8, 6, 5, 3, 13'h1FFF), 0, 0);
    step("lw_pos", mk(7, 1, 2, 3, 13'h0FFF), 0, 0);

    // Branches and jump
    step("beq", mk(9, 1, 2, 3, 13'h1000), 0, 0);
    step("blt", mk(10, 4, 7, 9, 13'h0004), 0, 0);
    step("ble", mk(11, 31, 31, 31, 13'h1FFE), 0, 0);
    step("jmp", {4'd12, 28'h0000010}, 0, 0);
    step("jmp_neg", {4'd12, 28'h8000000}, 0, 0);

    // Reserved opcodes and nop
    step("rsv15", mk(15, 3, 4, 5, 13'h0123), 0, 0);
    step("rsv13", mk(13, 7, 8, 9, 13'h1ABC), 0, 0);
    step("nop_add", mk(0, 5, 5, 2, 0), 1, 0);
    step("nop_rsv", mk(14, 1, 1, 1, 13'h1FFF), 1, 0);

    // Stall holds, including over a nop
    step("pre_stall", mk(7, 10, 11, 12, 13'h1F00), 0, 0);
    step("stall1", mk(1, 1, 2, 3, 0), 0, 1);
    step("stall2", mk(15, 0, 0, 0, 0), 0, 1);
    step("stall_nop", mk(4, 9, 9, 9, 0), 1, 1);
    step("post_stall", mk(2, 9, 9, 9, 0), 0, 0);

    // Asynchronous reset between edges
    step("pre_rst", mk(12, 31, 31, 31, 13'h1FFF), 0, 0);
    #3;
    rst = 1'b1;
    #1;
    exp_q = bubble_state();
    chk_all("async_rst");
    $display("async_rst: outputs cleared between edges");
    @(posedge clk);
    #1;
    chk_all("rst_held");
    rst = 1'b0;
    step("after_rst", mk(3, 2, 4, 6, 0), 0, 0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      step("rand", $urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/opd_32_decoder.md
# opd_32_decoder

Registered instruction decoder for the 32-bit CaballoLoco datapath, instantiated as `opd_32`. It splits a fetched instruction into register selects, control flags, ALU/compare opcodes and a sign-extended offset. It sits between fetch and register read / execute and presents one decoded bundle per cycle.

## Interface
- NUM_REG, 32, register-file depth; REG_SELECT = $clog2(NUM_REG) (local)
- REG_WIDTH, 32, instruction/offset width (local constant, not overridable)
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset; one clock, asynchronous, active-high
- i_instruction  in  32  instruction word
- i_nop  in  1  force bubble decode
- i_stall  in  1  hold the output register
- o_select_a  out  REG_SELECT  destination register field
- o_select_b  out  REG_SELECT  source 1 field
- o_select_c  out  REG_SELECT  source 2 field
- o_is_write  out  1  register write-back
- o_is_load  out  1  memory load
- o_is_store  out  1  memory store
- o_is_cmp  out  1  control transfer (branch/jump)
- o_cmp_op  out  cmp_op_e (2)  EQ=0, LT=1, LE=2, ALWAYS=3
- o_alu_op  out  alu_op_e (3)  ADD=0, SUB=1, AND=2, OR=3, MUL=4, DIV=5, XOR=6
- o_offset  out  32  sign-extended immediate
- o_illegal  out  1  reserved opcode seen

## Operation
- Fields: opcode = instr[31:28]; A = instr[27:23]; B = instr[22:18]; C = instr[17:13]; imm13 = instr[12:0].
- Opcodes: ADD=0, SUB=1, AND=2, OR=3, MUL=4, DIV=5, XOR=6, LW=7, SW=8, BEQ=9, BLT=10, BLE=11, JMP=12; 13–15 reserved.
- Selects are always A, B, C verbatim, for every opcode including nop/reserved.
- ADD..XOR: is_write=1; alu_op = matching op; offset=0; other flags 0.
- LW: is_write=1, is_load=1, alu_op=ADD, offset=sext(imm13).
- SW: is_store=1, alu_op=ADD, offset=sext(imm13).
- BEQ/BLT/BLE: is_cmp=1, cmp_op=EQ/LT/LE, alu_op=ADD, offset=sext(imm13).
- JMP: is_cmp=1, cmp_op=ALWAYS, alu_op=ADD, offset=sext(instr[27:0]).
- Bubble values: all four flags 0, alu_op=ADD, cmp_op=EQ, offset=0, o_illegal=0.
- i_nop=1: decode as bubble; selects still taken from the fields.
- Reserved opcode: bubble values, plus o_illegal=1 (see Configuration).
- Priority: i_rst > i_stall > i_nop > opcode decode.

## Timing
- All outputs are registered. Latency is 1 cycle: the bundle for the instruction sampled at edge N is valid after edge N.
- i_stall=1: every output holds its value, and i_instruction/i_nop are ignored.
- Reset (asynchronous, mid-operation too): all outputs clear immediately to bubble values, and selects clear to 0.
- First decode occurs on the first rising edge after i_rst deasserts.
- No handshake and no internal state beyond the output register.

## Configuration
- OPD_32_ILLEGAL_EN defined: reserved opcodes 13–15 assert o_illegal=1 for the cycle they are decoded.
- Without it: o_illegal is tied to 0, and reserved opcodes decode silently as bubbles.
- In both cases the o_illegal port exists.

## Test plan
- Reset asserted between edges -> all outputs 0 at once, alu_op=ADD, cmp_op=EQ.
- ADD A=5,B=5,C=2, then SUB/AND/OR/MUL/DIV/XOR with A=6,B=5,C=3 -> next cycle: sel 5/5/2 (then 6/5/3), is_write=1, alu_op=0..6 in turn, offset=0.
- LW A=6,B=5,C=3, imm13=0x1FFF -> is_load=1, is_write=1, offset=0xFFFFFFFF. SW with the same fields -> is_store=1, is_write=0.
- BEQ/BLT/BLE -> is_cmp=1, cmp_op=0/1/2, is_write=0. JMP with instr[27:0]=0x0000010 -> is_cmp=1, cmp_op=3, offset=16.
- Opcode 15 -> bubble outputs; o_illegal=1 only with OPD_32_ILLEGAL_EN. i_nop=1 with ADD -> flags 0, sel unchanged.
- i_stall=1 while the instruction changes -> outputs frozen. Stall and nop together -> hold wins.
